pulse_gen: RTL

Programmable-rate strobe generator that divides the board clock into a single-cycle enable pulse. It drives the `pulse_1hz` enable input of the downstream binary counter, replacing the constant-1 tie-off so the LED count is visible. It provides runtime rate selection, a synchronized run/stop control, and a heartbeat toggle for a status LED.

---
 rtl/pulse_gen.sv | 107 ++++++++++
 1 files changed

// File: rtl/pulse_gen.sv
// -----------------------------------------------------------------------------
// pulse_gen
//   Programmable-rate strobe generator. It divides the board clock down to a
//   single-cycle enable pulse that drives the downstream counter's pulse_1hz
//   input. The rate can be changed at runtime, a synchronized run/stop input
//   gates the strobe, and a heartbeat output toggles once per pulse for a
//   status LED.
//
// Parameters
//   CLK_HZ    input clock frequency in Hz
//   PULSE_HZ  base pulse rate in Hz at rate_sel = 0
//   SIM_DIV   if nonzero, replaces CLK_HZ/PULSE_HZ as the base divisor
//
// Ports
//   clk        board clock (single domain)
//   rst_n      asynchronous active-low reset
//   run        asynchronous run request; high enables pulsing
//   rate_sel   divisor = DIV >> rate_sel (x1, x2, x4, x8 rate)
//   pulse      registered strobe, one clk cycle high per period
//   heartbeat  registered, toggles on every pulse
//   active     synchronized run state
// -----------------------------------------------------------------------------
module pulse_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned PULSE_HZ = 1,
    parameter int unsigned SIM_DIV  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [1:0] rate_sel,
    output logic       pulse,
    output logic       heartbeat,
    output logic       active
);

    localparam int unsigned DIV = (SIM_DIV != 0) ? SIM_DIV : (CLK_HZ / PULSE_HZ);
    // cnt never exceeds DIV-1; div_cur has to hold DIV itself.
    localparam int CW = $clog2(DIV);
    localparam int DW = $clog2(DIV + 1);

    // DIV >= 16 keeps the fastest period (DIV>>3) at two cycles or more, so a
    // pulse can never be high on consecutive cycles.
    if (DIV < 16) begin : g_div_check
        $error("pulse_gen: base divisor must be at least 16");
    end

    logic          run_meta;
    logic          run_s;
    logic [CW-1:0] cnt;
    logic [DW-1:0] div_cur;
    logic [DW-1:0] div_sel;
    logic [CW-1:0] reload;

    // The selected period is sampled only when cnt is reloaded, so a rate_sel
    // change mid-period leaves the current period untouched.
    assign div_sel = DW'(DIV >> rate_sel);
    assign reload  = CW'(div_sel - DW'(1));

    // Two-flop synchronizer for the asynchronous run request.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
        end else begin
            run_meta <= run;
            run_s    <= run_meta;
        end
    end

    assign active = run_s;

    // Down-counter: run_s is tested first so a stop that lands on the cnt = 0
    // edge suppresses the pulse. While stopped the counter is held at a full
    // period, so a restart always waits one whole period before pulsing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= CW'(DIV - 1);
            div_cur   <= DW'(DIV);
            pulse     <= 1'b0;
            heartbeat <= 1'b0;
        end else if (!run_s) begin
            cnt     <= reload;
            div_cur <= div_sel;
            pulse   <= 1'b0;
        end else if (cnt != '0) begin
            cnt   <= cnt - CW'(1);
            pulse <= 1'b0;
        end else begin
            cnt       <= reload;
            div_cur   <= div_sel;
            pulse     <= 1'b1;
            heartbeat <= ~heartbeat;
        end
    end

    // The count always stays inside the period currently in force.
    a_cnt_in_period : assert property (@(posedge clk) disable iff (!rst_n)
        DW'(cnt) < div_cur);

    // Single-cycle strobe.
    a_pulse_single : assert property (@(posedge clk) disable iff (!rst_n)
        pulse |=> !pulse);

endmodule
